// File: rtl/pq_pkg.sv
// Shared ordering helper and sizing constants for the sorted-array priority queue.
// Keys up to PQ_KEY_MAX_W bits are compared; narrower keys are zero-extended first.
package pq_pkg;

  localparam bit PQ_ORDER_MIN_DEF = 1'b1;
  localparam int PQ_KEY_MAX_W     = 64;

  // Strict compare: equal keys are never "higher", which gives FIFO order on ties.
  function automatic logic higher_prio(input logic [PQ_KEY_MAX_W-1:0] a,
                                       input logic [PQ_KEY_MAX_W-1:0] b,
                                       input logic                    order_min);
    return order_min ? (a < b) : (a > b);
  endfunction

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pq_cell.sv
// One storage slot of the sorted array: holds, shifts down, shifts up or loads the new cell.
// Latency: next state registered on clk_i; no combinational path from inputs to cell_dat.
// Backpressure: none here; the top decides which single operation is active each cycle.
module pq_cell #(
  parameter type cell_t = logic [7:0],
  parameter bit  HEAD   = 1'b0
) (
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  push_only,
  input  logic  push_pop,
  input  logic  pop_only,
  input  logic  rm_shift,
  input  logic  b_above,
  input  logic  b_self,
  input  logic  b_below,
  input  cell_t above_dat,
  input  logic  above_vld,
  input  cell_t below_dat,
  input  logic  below_vld,
  input  cell_t new_dat,
  output cell_t cell_dat,
  output logic  cell_vld
);

  cell_t nxt_dat;
  logic  nxt_vld;

  // b_* flag: the new cell belongs at or before that index in the current order.
  always_comb begin
    nxt_dat = cell_dat;
    nxt_vld = cell_vld;
    if (push_only) begin
      if (b_above) begin
        nxt_dat = above_dat;
        nxt_vld = above_vld;
      end else if (b_self) begin
        nxt_dat = new_dat;
        nxt_vld = 1'b1;
      end
    end else if (push_pop) begin
      // Head leaves, so every index is judged against the array shifted up by one.
      if (b_self && !HEAD) begin
        nxt_dat = cell_dat;
        nxt_vld = cell_vld;
      end else if (b_below) begin
        nxt_dat = new_dat;
        nxt_vld = 1'b1;
      end else begin
        nxt_dat = below_dat;
        nxt_vld = below_vld;
      end
    end else if (pop_only || rm_shift) begin
      nxt_dat = below_dat;
      nxt_vld = below_vld;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cell_dat <= '0;
      cell_vld <= 1'b0;
    end else begin
      cell_dat <= nxt_dat;
      cell_vld <= nxt_vld;
    end
  end

endmodule

// File: rtl/pq_sorted_array.sv
// Register-array priority queue, sorted every cycle; optional remove-by-id under PQ_REMOVE_EN.
// Latency: head is a direct register peek; push/pop/remove effects visible the next cycle.
// Backpressure: none; push when full (no pop) is dropped with overflow_o, pop on empty flags underflow_o.
module pq_sorted_array
  import pq_pkg::*;
#(
  parameter  int QUEUE_DEPTH = 8,
  parameter  int TIME_WIDTH  = 32,
  parameter  bit ORDER_MIN   = PQ_ORDER_MIN_DEF,
  localparam int ID_WIDTH    = $clog2(QUEUE_DEPTH) + 1,
  localparam int CNT_WIDTH   = cnt_width(QUEUE_DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  push_i,
  input  logic [TIME_WIDTH-1:0] push_data_i,
  input  logic [ID_WIDTH-1:0]   push_id_i,
  input  logic                  pop_i,
  output logic                  head_valid_o,
  output logic [TIME_WIDTH-1:0] head_data_o,
  output logic [ID_WIDTH-1:0]   head_id_o,
  output logic [CNT_WIDTH-1:0]  cnt_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  overflow_o,
  output logic                  underflow_o
`ifdef PQ_REMOVE_EN
  ,
  input  logic                  remove_i,
  input  logic [ID_WIDTH-1:0]   remove_id_i,
  output logic                  remove_hit_o
`endif
);

  typedef struct packed {
    logic [TIME_WIDTH-1:0] data;
    logic [ID_WIDTH-1:0]   id;
  } cell_t;

  cell_t                  cells [QUEUE_DEPTH];
  cell_t                  new_cell;
  logic [QUEUE_DEPTH-1:0] vld, ins_at, rm_shift;
  logic [CNT_WIDTH-1:0]   cnt;
  logic full, empty, push_ok, pop_ok, push_only, push_pop, pop_only, rm_hit;

  assign new_cell  = '{data: push_data_i, id: push_id_i};
  assign full      = (cnt == CNT_WIDTH'(QUEUE_DEPTH));
  assign empty     = (cnt == '0);
  assign push_ok   = push_i && (!full || pop_i);
  assign pop_ok    = pop_i && !empty;
  assign push_only = push_ok && !pop_ok;
  assign push_pop  = push_ok && pop_ok;
  assign pop_only  = pop_ok && !push_ok;

  // Monotonic over the index because valid cells are contiguous and sorted.
  always_comb begin
    ins_at = '0;
    for (int i = 0; i < QUEUE_DEPTH; i++)
      ins_at[i] = !vld[i] || higher_prio(PQ_KEY_MAX_W'(push_data_i),
                                         PQ_KEY_MAX_W'(cells[i].data), ORDER_MIN);
  end

`ifdef PQ_REMOVE_EN
  logic                   rm_act;
  logic [QUEUE_DEPTH-1:0] rm_match;

  assign rm_act = remove_i && !push_i && !pop_i;

  // Everything from the first matching index downward shifts up by one.
  always_comb begin
    rm_match = '0;
    rm_shift = '0;
    for (int i = 0; i < QUEUE_DEPTH; i++)
      rm_match[i] = vld[i] && (cells[i].id == remove_id_i);
    rm_shift[0] = rm_act && rm_match[0];
    for (int i = 1; i < QUEUE_DEPTH; i++)
      rm_shift[i] = rm_shift[i-1] || (rm_act && rm_match[i]);
  end

  assign rm_hit = rm_act && (|rm_match);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) remove_hit_o <= 1'b0;
    else         remove_hit_o <= rm_hit;
  end
`else
  assign rm_shift = '0;
  assign rm_hit   = 1'b0;
`endif

  for (genvar i = 0; i < QUEUE_DEPTH; i++) begin : g_cell
    cell_t above_dat, below_dat;
    logic  above_vld, below_vld, b_above, b_below;

    if (i == 0) begin : g_first
      assign above_dat = '0;
      assign above_vld = 1'b0;
      assign b_above   = 1'b0;
    end else begin : g_inner_a
      assign above_dat = cells[i-1];
      assign above_vld = vld[i-1];
      assign b_above   = ins_at[i-1];
    end

    if (i == QUEUE_DEPTH - 1) begin : g_last
      assign below_dat = '0;
      assign below_vld = 1'b0;
      assign b_below   = 1'b1;
    end else begin : g_inner_b
      assign below_dat = cells[i+1];
      assign below_vld = vld[i+1];
      assign b_below   = ins_at[i+1];
    end

    pq_cell #(.cell_t(cell_t), .HEAD(i == 0)) u_cell (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .push_only(push_only),
      .push_pop (push_pop),
      .pop_only (pop_only),
      .rm_shift (rm_shift[i]),
      .b_above  (b_above),
      .b_self   (ins_at[i]),
      .b_below  (b_below),
      .above_dat(above_dat),
      .above_vld(above_vld),
      .below_dat(below_dat),
      .below_vld(below_vld),
      .new_dat  (new_cell),
      .cell_dat (cells[i]),
      .cell_vld (vld[i])
    );
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt         <= '0;
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      if (push_only)               cnt <= cnt + 1'b1;
      else if (pop_only || rm_hit) cnt <= cnt - 1'b1;
      overflow_o  <= push_i && full && !pop_i;
      underflow_o <= pop_i && empty;
    end
  end

  assign head_valid_o = vld[0];
  assign head_data_o  = cells[0].data;
  assign head_id_o    = cells[0].id;
  assign cnt_o        = cnt;
  assign full_o       = full;
  assign empty_o      = empty;

endmodule
